// File: rtl/branch_target_predictor_pkg.sv
// Shared types and constants for the branch target predictor.
// Entry layout, counter encodings and PC tag extraction.
package branch_target_predictor_pkg;

    localparam int PC_W  = 32;
    localparam int TAG_W = 30;
    localparam int CTR_W = 2;

    localparam logic [CTR_W-1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [CTR_W-1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [CTR_W-1:0] CTR_STRONG_T  = 2'b11;

    // Tag field is sized for the smallest table; unused
    // upper bits are always zero.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    function automatic logic [TAG_W-1:0] pc_tag(
        input logic [PC_W-1:0] pc,
        input int unsigned     index_bits
    );
        return pc[PC_W-1:2] >> index_bits;
    endfunction

endpackage

// File: rtl/branch_target_predictor_entry_update.sv
// btb_entry_update: combinational next-entry computation.
// Ports: cur_i/hit_i/taken_i/target_i/tag_i -> nxt_o, we_o.
module btb_entry_update
    import branch_target_predictor_pkg::*;
(
    input  btb_entry_t        cur_i,
    input  logic              hit_i,
    input  logic              taken_i,
    input  logic [PC_W-1:0]   target_i,
    input  logic [TAG_W-1:0]  tag_i,
    output btb_entry_t        nxt_o,
    output logic              we_o
);

    always_comb begin
        nxt_o = cur_i;
        we_o  = 1'b0;
        if (hit_i) begin
            we_o = 1'b1;
            if (taken_i) begin
                nxt_o.target = target_i;
                if (cur_i.ctr != CTR_STRONG_T) begin
                    nxt_o.ctr = cur_i.ctr + 2'd1;
                end
            end else if (cur_i.ctr != CTR_STRONG_NT) begin
                nxt_o.ctr = cur_i.ctr - 2'd1;
            end
        end else if (taken_i) begin
            // Allocation overwrites whatever aliased here.
            we_o         = 1'b1;
            nxt_o.valid  = 1'b1;
            nxt_o.tag    = tag_i;
            nxt_o.target = target_i;
            nxt_o.ctr    = CTR_WEAK_T;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters and a forwarded update stage.
// Ports: fetch lookup, resolved-branch update, lookup/mispredict stats.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pred_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
);

    localparam int INDEX_BITS = $clog2(ENTRIES);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    logic                  stg_valid_q;
    logic [INDEX_BITS-1:0] stg_idx_q;
    btb_entry_t            stg_q;

    logic [31:0] lookups_q;
    logic [31:0] mispred_q;

    logic [INDEX_BITS-1:0] f_idx;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      f_tag;
    logic [TAG_W-1:0]      u_tag;
    btb_entry_t            f_eff;
    btb_entry_t            u_eff;
    logic                  u_hit;
    btb_entry_t            u_nxt;
    logic                  u_we;

    logic unused_ok;
    assign unused_ok = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign u_idx = upd_pc[INDEX_BITS+1:2];
    assign f_tag = pc_tag(fetch_pc, INDEX_BITS);
    assign u_tag = pc_tag(upd_pc, INDEX_BITS);

    // The stage holds the newest copy of its index until written back.
    always_comb begin
        f_eff = '{valid:  valid_q[f_idx],
                  tag:    tag_q[f_idx],
                  target: target_q[f_idx],
                  ctr:    ctr_q[f_idx]};
        if (stg_valid_q && stg_idx_q == f_idx) begin
            f_eff = stg_q;
        end
    end

    always_comb begin
        u_eff = '{valid:  valid_q[u_idx],
                  tag:    tag_q[u_idx],
                  target: target_q[u_idx],
                  ctr:    ctr_q[u_idx]};
        if (stg_valid_q && stg_idx_q == u_idx) begin
            u_eff = stg_q;
        end
    end

    assign u_hit = u_eff.valid && (u_eff.tag == u_tag);

    btb_entry_update u_update (
        .cur_i    (u_eff),
        .hit_i    (u_hit),
        .taken_i  (upd_taken),
        .target_i (upd_target),
        .tag_i    (u_tag),
        .nxt_o    (u_nxt),
        .we_o     (u_we)
    );

    assign pred_hit    = fetch_valid && f_eff.valid
                         && (f_eff.tag == f_tag);
    assign pred_taken  = pred_hit && f_eff.ctr[1];
    assign pred_target = pred_hit ? f_eff.target : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
        end else begin
            stg_valid_q <= upd_valid && u_we;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid) begin
            stg_q     <= u_nxt;
            stg_idx_q <= u_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (stg_valid_q) begin
            valid_q[stg_idx_q] <= stg_q.valid;
            ctr_q[stg_idx_q]   <= stg_q.ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && stg_valid_q) begin
            tag_q[stg_idx_q]    <= stg_q.tag;
            target_q[stg_idx_q] <= stg_q.target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            if (fetch_valid && lookups_q != '1) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (upd_valid && upd_mispredict && mispred_q != '1) begin
                mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor.
// One task per scenario, inline comparisons.
module tb_branch_target_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_target_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_valid      (fetch_valid),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_hit         (pred_hit),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mis;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        fetch_pc = 32'h100;
        fetch_valid = 1'b1;
        #1;
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit got=%0h exp=0", pred_hit);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_taken got=%0h exp=0", pred_taken);
        end
        checks++;
        if (pred_target !== 32'h0) begin
            errors++;
            $display("FAIL reset_target got=%h exp=0", pred_target);
        end
        checks++;
        if (stat_lookups !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got=%0d/%0d exp=0/0",
                     stat_lookups, stat_mispredicts);
        end
        tick();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (stat_lookups !== 32'd1) begin
            errors++;
            $display("FAIL lookups_one got=%0d exp=1", stat_lookups);
        end
    endtask

    task automatic test_alloc();
        fetch_pc = 32'h100;
        fetch_valid = 1'b1;
        set_upd(32'h100, 1'b1, 32'h200, 1'b0);
        #1;
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL alloc_same_cycle got=%0h exp=0", pred_hit);
        end
        tick();
        upd_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (pred_hit !== 1'b1 || pred_taken !== 1'b1
                || pred_target !== 32'h200) begin
                errors++;
                $display("FAIL alloc_n%0d got=%0h/%0h/%h exp=1/1/200",
                         c + 1, pred_hit, pred_taken, pred_target);
            end
            tick();
        end
    endtask

    task automatic test_counter_walk();
        logic [4:0] tk_seq;
        logic [4:0] exp_tk;
        tk_seq = 5'b11000;
        exp_tk = 5'b10000;
        fetch_pc = 32'h100;
        fetch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_upd(32'h100, tk_seq[i], 32'h200, 1'b0);
            tick();
            upd_valid = 1'b0;
            #1;
            checks++;
            if (pred_hit !== 1'b1 || pred_taken !== exp_tk[i]) begin
                errors++;
                $display("FAIL walk_%0d got=%0h/%0h exp=1/%0h",
                         i, pred_hit, pred_taken, exp_tk[i]);
            end
        end
        tick();
    endtask

    task automatic test_alias();
        set_upd(32'h140, 1'b1, 32'h300, 1'b0);
        tick();
        upd_valid = 1'b0;
        fetch_pc = 32'h100;
        fetch_valid = 1'b1;
        #1;
        checks++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0
            || pred_target !== 32'h0) begin
            errors++;
            $display("FAIL alias_old got=%0h/%0h/%h exp=0/0/0",
                     pred_hit, pred_taken, pred_target);
        end
        fetch_pc = 32'h140;
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h300) begin
            errors++;
            $display("FAIL alias_new got=%0h/%h exp=1/300",
                     pred_hit, pred_target);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] tk_seq;
        tk_seq = 3'b011;
        fetch_pc = 32'h180;
        fetch_valid = 1'b1;
        set_upd(32'h180, 1'b1, 32'h380, 1'b0);
        #1;
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_n got=%0h exp=0", pred_hit);
        end
        for (int i = 1; i < 3; i++) begin
            tick();
            set_upd(32'h180, tk_seq[i], 32'h380, 1'b0);
            #1;
            checks++;
            if (pred_taken !== 1'b1 || pred_target !== 32'h380) begin
                errors++;
                $display("FAIL b2b_n%0d got=%0h/%h exp=1/380",
                         i, pred_taken, pred_target);
            end
        end
        tick();
        upd_valid = 1'b0;
        for (int i = 3; i < 5; i++) begin
            #1;
            checks++;
            if (pred_taken !== 1'b1) begin
                errors++;
                $display("FAIL b2b_n%0d got=%0h exp=1", i, pred_taken);
            end
            tick();
        end
        set_upd(32'h180, 1'b0, 32'h0, 1'b0);
        tick();
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final got=%0h/%0h exp=1/0",
                     pred_hit, pred_taken);
        end
        tick();
    endtask

    task automatic test_stats_reset();
        fetch_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_upd(32'h100, 1'b1, 32'h200, (i != 2));
            tick();
        end
        upd_valid = 1'b0;
        #1;
        checks++;
        if (stat_mispredicts !== 32'd3) begin
            errors++;
            $display("FAIL stat_mis got=%0d exp=3", stat_mispredicts);
        end
        checks++;
        if (stat_lookups !== 32'd0) begin
            errors++;
            $display("FAIL stat_lk0 got=%0d exp=0", stat_lookups);
        end
        fetch_valid = 1'b1;
        tick();
        tick();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (stat_lookups !== 32'd2) begin
            errors++;
            $display("FAIL stat_lk2 got=%0d exp=2", stat_lookups);
        end
        set_upd(32'h1C0, 1'b1, 32'h400, 1'b1);
        tick();
        rst = 1'b1;
        set_upd(32'h240, 1'b1, 32'h500, 1'b1);
        tick();
        rst = 1'b0;
        upd_valid = 1'b0;
        fetch_valid = 1'b1;
        fetch_pc = 32'h1C0;
        #1;
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h0) begin
            errors++;
            $display("FAIL rst_pending got=%0h/%h exp=0/0",
                     pred_hit, pred_target);
        end
        fetch_pc = 32'h240;
        #1;
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL rst_upd_ign got=%0h exp=0", pred_hit);
        end
        checks++;
        if (stat_lookups !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL rst_stats got=%0d/%0d exp=0/0",
                     stat_lookups, stat_mispredicts);
        end
        tick();
        fetch_valid = 1'b0;
        tick();
        checks++;
        if (pred_hit !== 1'b0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL rst_late got=%0h/%0d exp=0/0",
                     pred_hit, stat_mispredicts);
        end
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = '0;
        fetch_valid = 1'b0;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_mispredict = 1'b0;
        test_reset();
        test_alloc();
        test_counter_walk();
        test_alias();
        test_back_to_back();
        test_stats_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Branch predictor that generates the prediction consumed by the next-PC decision logic and learns from resolved branches in execute. Lookup is a direct-mapped branch target buffer with 2-bit saturating counters. Fetch presents a PC and gets back a taken flag and target in the same cycle. Execute returns resolved outcomes through a registered update stage with forwarding. Sits beside the fetch PC register: outputs feed `branch_prediction_actual` / `pc_target_prediction_actual`, and update inputs come from the branch resolution path.

## Interface
- `ENTRIES`, 16, number of BTB entries; power of two, 4..256
- `INDEX_BITS`, $clog2(ENTRIES), derived, not overridden
- `CTR_INIT`, 2'b01, counter value loaded at reset (weakly not-taken)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `fetch_pc`  in  32  PC being fetched this cycle
- `fetch_valid`  in  1  `fetch_pc` is a real lookup
- `pred_taken`  out  1  predicted taken
- `pred_target`  out  32  predicted target; 0 when not hit
- `pred_hit`  out  1  valid entry with matching tag
- `upd_valid`  in  1  resolved branch present this cycle
- `upd_pc`  in  32  PC of the resolved branch
- `upd_taken`  in  1  actual branch outcome
- `upd_target`  in  32  computed branch target
- `upd_mispredict`  in  1  propagated prediction differed from outcome (statistics only)
- `stat_lookups`  out  32  count of cycles with `fetch_valid`=1
- `stat_mispredicts`  out  32  count of updates with `upd_mispredict`=1

## Operation
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
  - pc[1:0] ignored
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Counter encoding:
  - 00 strong NT, 01 weak NT, 10 weak T, 11 strong T
  - predicts taken iff ctr[1]=1
  - saturates at 00 and 11
- Lookup (combinational from state):
  - `pred_hit` = fetch_valid & effective entry valid & tag match
  - `pred_taken` = pred_hit & ctr[1]
  - `pred_target` = entry target if pred_hit, else 0
- Effective entry:
  - the update stage contents, if the stage is valid with the same index
  - otherwise the array contents
- Update capture (edge at end of cycle N with upd_valid=1): next entry is computed from the effective entry at upd_pc's index, then stored in the stage register with its index.
  - Hit, taken: ctr+1 (sat), target=upd_target.
  - Hit, not-taken: ctr-1 (sat), target unchanged.
  - Miss, taken: allocate. valid=1, tag, target=upd_target, ctr=10. Replaces any aliased entry.
  - Miss, not-taken: no change; stage is not loaded (stage valid=0).
- Write: a valid stage is written into the array on the next edge (end of N+1).
- Back-to-back updates to the same index chain correctly, because capture reads through the forwarded stage.
- Statistics: both counters saturate at 0xFFFFFFFF; they never wrap.

## Timing
- Lookup latency is 0 cycles (combinational); there are no lookup stalls.
- An update sampled at the end of cycle N is visible to lookups from cycle N+1 (forwarded). It is in the array from cycle N+2.
- A lookup and a capture in the same cycle: the lookup sees pre-update state.
- Reset (end of any cycle with rst=1):
  - all valid=0; all ctr=CTR_INIT
  - stage valid=0; a pending write is discarded
  - statistics=0
  - tags/targets are don't-care
- Outputs after reset: `pred_taken`=0, `pred_target`=0, `pred_hit`=0, statistics=0.
- `upd_valid` during rst is ignored.
- Statistic increments from cycle N are visible from cycle N+1.

## Structure
- Shared package constants:
  - CTR_STRONG_NT=2'b00, CTR_WEAK_NT=2'b01, CTR_WEAK_T=2'b10, CTR_STRONG_T=2'b11
  - BTB entry field widths
- Sub-module `btb_entry_update`: purely combinational. Maps (effective entry, tag match, upd_taken, upd_target, upd tag) to (next entry, write enable).
- Top-level contents: the array, the stage register, forwarding muxes and statistics counters.

## Test plan
- Reset, then fetch_pc=0x100 with fetch_valid=1: pred_hit=0, pred_taken=0, pred_target=0; stat_lookups=1 next cycle.
- Update 0x100 taken, target 0x200, in cycle N:
  - fetch 0x100 in N+1 gives hit=1, taken=1, target=0x200 (forwarded)
  - identical in N+2 (from array)
- Counter walk after the previous test (ctr=10):
  - not-taken x3 to 0x100 gives ctr 01, 00, 00; pred_taken=0, hit=1
  - then taken gives 01; pred_taken still 0
- Alias (ENTRIES=16): 0x100 allocated, then update 0x140 taken, target 0x300 → fetch 0x100 hit=0; fetch 0x140 gives target 0x300.
- Back-to-back 0x180 taken (N), taken (N+1), not-taken (N+2) → ctr 10, 11, 10; pred_taken=1 throughout from N+1.
- Statistics and reset:
  - three upd_mispredict=1 updates give stat_mispredicts=3
  - update 0x1C0 taken at N, rst=1 at N+1 gives fetch 0x1C0 hit=0 and stats=0 afterwards
